// File: rtl/acq_buffer_ctrl_if.sv
// Bundle of control, sample-stream, buffer-RAM and readout signals for acq_buffer_ctrl.
// The controller takes the slave view; the surrounding system (ADC, RAM, consumer) takes master.
interface acq_buffer_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] pretrig_len;
    logic [DATA_WIDTH-1:0] adc_data;
    logic                  adc_valid;
    logic                  trigger;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_din;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_dout;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, pretrig_len, adc_data, adc_valid, trigger, ram_dout, out_ready,
        output ram_waddr, ram_din, ram_we, ram_raddr, out_data, out_valid, busy, done
    );

    modport master (
        output start, pretrig_len, adc_data, adc_valid, trigger, ram_dout, out_ready,
        input  ram_waddr, ram_din, ram_we, ram_raddr, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/acq_buffer_ctrl.sv
// Pre/post-trigger acquisition controller: streams samples into a circular buffer RAM,
// then reads back the N-sample window around the trigger over a valid/ready port.
module acq_buffer_ctrl #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    acq_buffer_ctrl_if.slave bus
);
    localparam int N  = 1 << ADDR_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [CW-1:0]         cnt_t;

    localparam cnt_t N_CNT    = cnt_t'(N);
    localparam cnt_t LAST_CNT = cnt_t'(N - 1);

    typedef enum logic [2:0] {
        IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, RD_REQ, RD_WAIT, RD_OUT
    } state_t;

    state_t state, state_nxt;

    addr_t p_len, wp, rd_ptr, ram_waddr;
    data_t ram_din, out_data;
    logic  ram_we, done;
    cnt_t  cnt, post_target;
    logic  capturing, accept, trig_hit, handshake, last_hs;

    // cnt counts pre-trigger writes, then post-trigger writes, then readout handshakes.
    assign post_target = N_CNT - cnt_t'(p_len);
    assign capturing   = (state == PRE_FILL) || (state == WAIT_TRIG) ||
                         ((state == POST_FILL) && (cnt != post_target));
    assign accept      = capturing && bus.adc_valid;
    assign trig_hit    = (state == WAIT_TRIG) && bus.adc_valid && bus.trigger;
    assign handshake   = (state == RD_OUT) && bus.out_ready;
    assign last_hs     = handshake && (cnt == LAST_CNT);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order or process scheduling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (bus.start) state_nxt = (bus.pretrig_len == '0) ? WAIT_TRIG : PRE_FILL;
            PRE_FILL:  if (accept && (cnt_t'(cnt + 1'b1) == cnt_t'(p_len))) state_nxt = WAIT_TRIG;
            WAIT_TRIG: if (trig_hit) state_nxt = POST_FILL;
            // Leave only once the last write is on the RAM port (ram_we high this cycle).
            POST_FILL: if (cnt == post_target) state_nxt = RD_REQ;
            RD_REQ:    state_nxt = RD_WAIT;
            RD_WAIT:   state_nxt = RD_OUT;
            RD_OUT:    if (handshake) state_nxt = last_hs ? IDLE : RD_REQ;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_len     <= '0;
            wp        <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_din   <= '0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            ram_we <= accept;
            done   <= last_hs;
            if (accept) begin
                ram_waddr <= wp;
                ram_din   <= bus.adc_data;
                wp        <= wp + addr_t'(1);
            end
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        p_len <= bus.pretrig_len;
                        wp    <= '0;
                        cnt   <= '0;
                    end
                end
                PRE_FILL: if (accept) cnt <= cnt + 1'b1;
                WAIT_TRIG: begin
                    // Window starts P samples before the trigger sample's address.
                    if (trig_hit) begin
                        rd_ptr <= wp - p_len;
                        cnt    <= cnt_t'(1);
                    end
                end
                POST_FILL: begin
                    if (accept)                  cnt <= cnt + 1'b1;
                    else if (cnt == post_target) cnt <= '0;
                end
                RD_REQ:  ;
                RD_WAIT: out_data <= bus.ram_dout;
                RD_OUT: begin
                    if (handshake) begin
                        rd_ptr <= rd_ptr + addr_t'(1);
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ram_we    = ram_we;
    assign bus.ram_waddr = ram_waddr;
    assign bus.ram_din   = ram_din;
    assign bus.ram_raddr = rd_ptr;
    assign bus.out_data  = out_data;
    assign bus.out_valid = (state == RD_OUT);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done;
endmodule

// File: tb/tb_acq_buffer_ctrl.sv
// Directed bench for acq_buffer_ctrl with N=16: table of acquisition scenarios driven by
// a ramp source, a behavioural buffer RAM, and hand sequences for reset mid-readout.
module tb_acq_buffer_ctrl;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int N  = 16;
    localparam int NV = 7;

    typedef struct {
        int p;
        int trig;
        int early_a;
        int early_b;
        int nv_trig;
        bit stall;
        bit start_noise;
        int abort_after;
        int first;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    acq_buffer_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    acq_buffer_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] mem [N];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input int p, input int trig, input int ea, input int eb,
                                input int nv, input bit stall, input bit noise,
                                input int abort_n, input int first);
        vec_t v;
        v.p = p; v.trig = trig; v.early_a = ea; v.early_b = eb; v.nv_trig = nv;
        v.stall = stall; v.start_noise = noise; v.abort_after = abort_n; v.first = first;
        return v;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ram_we"},    32'(bus.ram_we),    32'd0);
        check({tag, "_ram_waddr"}, 32'(bus.ram_waddr), 32'd0);
        check({tag, "_ram_din"},   32'(bus.ram_din),   32'd0);
        check({tag, "_ram_raddr"}, 32'(bus.ram_raddr), 32'd0);
        check({tag, "_out_data"},  32'(bus.out_data),  32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
    endtask

    // One acquisition: start, ramp samples 0,1,2,... every cycle, then collect the readout.
    task automatic run_acq(input int id, input vec_t v);
        int s = 0;
        int idx = 0;
        int cyc = 0;
        int vcnt = 0;
        int we_in_rd = 0;
        bit seen_valid = 1'b0;
        bit gap_done = 1'b0;
        bit noise_rd_done = 1'b0;
        bit prev_valid;
        bit hs;

        check($sformatf("v%0d_idle_busy", id), 32'(bus.busy), 32'd0);
        bus.start       = 1'b1;
        bus.pretrig_len = AW'(v.p);
        bus.adc_valid   = 1'b0;
        bus.trigger     = 1'b0;
        bus.out_ready   = 1'b0;
        tick();
        bus.start       = 1'b0;
        bus.pretrig_len = AW'(9);
        check($sformatf("v%0d_busy", id), 32'(bus.busy), 32'd1);

        while (idx < N && cyc < 600) begin
            bus.start = 1'b0;
            if (v.nv_trig == s && !gap_done) begin
                bus.adc_valid = 1'b0;
                bus.trigger   = 1'b1;
                gap_done      = 1'b1;
            end else begin
                bus.adc_valid = 1'b1;
                bus.adc_data  = DW'(s);
                bus.trigger   = (s == v.trig) || (s == v.early_a) || (s == v.early_b);
                if (v.start_noise && s == 10) bus.start = 1'b1;
                s++;
            end
            if (v.start_noise && bus.out_valid && !noise_rd_done) begin
                bus.start     = 1'b1;
                noise_rd_done = 1'b1;
            end
            bus.out_ready = v.stall ? (vcnt == 2) : 1'b1;
            hs = bus.out_valid && bus.out_ready;
            if (hs) check($sformatf("v%0d_out%0d", id, idx), 32'(bus.out_data), 32'(v.first + idx));
            prev_valid = bus.out_valid;

            tick();
            cyc++;
            if (seen_valid && bus.ram_we) we_in_rd++;
            if (bus.out_valid) seen_valid = 1'b1;

            if (hs) begin
                idx++;
                vcnt = 0;
                if (idx == N) begin
                    check($sformatf("v%0d_done", id),      32'(bus.done),      32'd1);
                    check($sformatf("v%0d_busy_end", id),  32'(bus.busy),      32'd0);
                    check($sformatf("v%0d_valid_end", id), 32'(bus.out_valid), 32'd0);
                end else begin
                    check($sformatf("v%0d_valid_drop%0d", id, idx), 32'(bus.out_valid), 32'd0);
                end
                if (v.abort_after > 0 && idx == v.abort_after) break;
            end else if (prev_valid) begin
                vcnt++;
                check($sformatf("v%0d_hold_valid%0d", id, idx), 32'(bus.out_valid), 32'd1);
                check($sformatf("v%0d_hold_data%0d", id, idx),  32'(bus.out_data),  32'(v.first + idx));
            end
        end

        if (v.abort_after == 0) begin
            check($sformatf("v%0d_sample_count", id), 32'(idx), 32'(N));
            bus.adc_valid = 1'b0;
            bus.trigger   = 1'b0;
            bus.out_ready = 1'b0;
            bus.start     = 1'b0;
            tick();
            check($sformatf("v%0d_done_pulse", id), 32'(bus.done), 32'd0);
            check($sformatf("v%0d_rd_no_write", id), 32'(we_in_rd), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.pretrig_len = '0;
        bus.adc_data    = '0;
        bus.adc_valid   = 1'b0;
        bus.trigger     = 1'b0;
        bus.out_ready   = 1'b0;

        //              p   trig ea  eb  nv  stall noise abort first
        vecs[0] = mk(   4,  20,  -1, -1, -1, 1'b0, 1'b0, 0,    16);
        vecs[1] = mk(   0,   5,  -1, -1,  3, 1'b0, 1'b0, 0,     5);
        vecs[2] = mk(   8,  30,   3,  6, -1, 1'b0, 1'b0, 0,    22);
        vecs[3] = mk(   4,  20,  -1, -1, -1, 1'b1, 1'b0, 0,    16);
        vecs[4] = mk(  15,  17,  -1, -1, -1, 1'b0, 1'b0, 0,     2);
        vecs[5] = mk(   1,   1,  -1, -1, -1, 1'b0, 1'b0, 0,     0);
        vecs[6] = mk(   4,  20,  -1, -1, -1, 1'b0, 1'b1, 0,    16);

        repeat (3) @(posedge clk);
        #1;
        check_zero_outputs("por");
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_acq(i, vecs[i]);
            tick();
        end

        // Reset in the middle of readout, then a fresh acquisition.
        run_acq(7, mk(4, 20, -1, -1, -1, 1'b0, 1'b0, 5, 16));
        #2 rst = 1'b1;
        #1;
        check_zero_outputs("midrd_rst");
        bus.adc_valid = 1'b0;
        bus.trigger   = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_acq(8, mk(4, 40, -1, -1, -1, 1'b0, 1'b0, 0, 36));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/acq_buffer_ctrl.md
ACQ_BUFFER_CTRL -- requirements
Module: acq_buffer_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, sample buffer address width; depth N = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, sample width.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle request to begin an acquisition.
REQ-006 pretrig_len  input  ADDR_WIDTH  pre-trigger sample count P, latched on accepted start.
REQ-007 adc_data  input  DATA_WIDTH  incoming sample.
REQ-008 adc_valid  input  1  adc_data valid this cycle; no backpressure.
REQ-009 trigger  input  1  trigger event, qualified by adc_valid.
REQ-010 ram_waddr  output  ADDR_WIDTH  buffer RAM write address.
REQ-011 ram_din  output  DATA_WIDTH  buffer RAM write data.
REQ-012 ram_we  output  1  buffer RAM write enable.
REQ-013 ram_raddr  output  ADDR_WIDTH  buffer RAM read address.
REQ-014 ram_dout  input  DATA_WIDTH  buffer RAM read data; valid the cycle after ram_raddr is presented.
REQ-015 out_data  output  DATA_WIDTH  readout sample.
REQ-016 out_valid  output  1  out_data valid; held until out_ready.
REQ-017 out_ready  input  1  downstream accepts out_data when high with out_valid.
REQ-018 busy  output  1  high from accepted start until done.
REQ-019 done  output  1  one-cycle pulse on final readout handshake.

Function
REQ-020 States SHALL be IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, RD_REQ, RD_WAIT, RD_OUT.
REQ-021 IDLE: start SHALL latch P, clear write pointer wp to 0, go PRE_FILL (P>0) or WAIT_TRIG (P=0); start outside IDLE SHALL be ignored.
REQ-022 Every adc_valid cycle in PRE_FILL, WAIT_TRIG, POST_FILL SHALL write adc_data at wp, then wp = wp+1 mod N (wraps, no error).
REQ-023 Writes SHALL be registered: sample accepted at edge k drives ram_we=1, ram_waddr, ram_din during cycle k+1; ram_we=0 otherwise.
REQ-024 PRE_FILL SHALL ignore trigger and go WAIT_TRIG once P samples are written.
REQ-025 WAIT_TRIG: trigger=1 with adc_valid=1 SHALL write that sample as first post-trigger sample, record trig_addr=wp, go POST_FILL; trigger without adc_valid SHALL be ignored.
REQ-026 POST_FILL SHALL end after N-P samples total including trigger sample, then go RD_REQ only after the final write has been issued on the RAM port.
REQ-027 Readout SHALL start at rd_ptr = (trig_addr - P) mod N and return exactly N samples in ascending address order with wrap; trigger sample is output index P.
REQ-028 RD_REQ drives ram_raddr=rd_ptr; RD_WAIT captures ram_dout into out_data; RD_OUT asserts out_valid.
REQ-029 In RD_OUT, out_valid and out_data SHALL stay stable while out_ready=0; on handshake rd_ptr increments, next state RD_REQ, or IDLE with done=1 after the N-th handshake.
REQ-030 Minimum readout rate SHALL be one sample per 3 cycles; out_valid SHALL deassert the cycle after a handshake.
REQ-031 adc_valid during RD_* or IDLE SHALL be discarded; no RAM writes occur.
REQ-032 busy SHALL be 1 in all states except IDLE; done and busy SHALL never be 1 simultaneously after the done cycle.

Reset
REQ-033 rst SHALL force, asynchronously, state IDLE, wp=0, rd_ptr=0, ram_we=0, ram_waddr=0, ram_din=0, ram_raddr=0, out_data=0, out_valid=0, busy=0, done=0.
REQ-034 rst mid-acquisition or mid-readout SHALL abandon the operation; next start SHALL behave as from power-up.

Verification (ADDR_WIDTH=4, N=16, adc_data ramp 0,1,2,... with adc_valid=1, out_ready=1 unless stated)
REQ-035 P=4, trigger with sample 20 -> out_data 16..31 in order, index 4 = 20, done after 16th handshake, busy falls same cycle.
REQ-036 P=0, trigger with sample 5 -> out_data 5..20.
REQ-037 P=8, trigger pulsed at samples 3 and 6 (PRE_FILL) then at 30 -> triggers at 3 and 6 ignored; out_data 22..37.
REQ-038 out_ready toggled 0,0,1 repeatedly -> out_valid/out_data stable while low; sequence unchanged, no duplicates or drops.
REQ-039 rst asserted during readout after 5 handshakes -> all outputs 0 immediately; new start with P=4, trigger at 40 (samples renumbered from restart) -> correct 16-sample window.
REQ-040 start pulsed in WAIT_TRIG and RD_OUT -> ignored; P unchanged; adc_valid during readout -> no ram_we.
